// File: rtl/hex_display_bank.sv
// hex_display_bank
//   Multi-digit seven-segment display driver. A value is loaded through a
//   valid/ready handshake and shown across NDIGITS active-low displays. Hex
//   mode shows the value directly. Decimal mode first converts it to BCD with
//   an iterative double-dabble, one step per cycle. The driver also supports
//   leading-zero blanking, a per-digit enable mask, an overflow dash display
//   and an optional whole-display blink.
//
//   Ports:
//     clk, reset   system clock, synchronous active-high reset
//     in_valid     load request
//     in_ready     high in IDLE; the block can accept a load
//     in_value     W = 4*NDIGITS bit value; hex digit i = in_value[4*i+3:4*i]
//     in_decimal   1 = convert to decimal (sampled on accept)
//     blank_lz     blank leading zero digits (sampled on accept)
//     blink        level input; blinks the whole display
//     digit_en     live per-digit enable; 0 blanks digit i
//     segments     digit i at [7*i+6:7*i], bit 6 = a ... bit 0 = g, active-low
//     overflow     the last decimal load exceeded 10^NDIGITS-1
//
//   Configuration macro: HEX_DISPLAY_BLINK_EN
//     defined   -> blink counter and blink-off blanking are built in
//     undefined -> no counter logic; the blink port is accepted and ignored
//
//   state | meaning
//   IDLE  | waiting for a load; in_ready = 1
//   CONV  | double-dabble in progress, W steps; in_ready = 0

module hex_display_bank #(
  parameter int NDIGITS   = 6,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NDIGITS-1:0]   in_value,
  input  logic                   in_decimal,
  input  logic                   blank_lz,
  input  logic                   blink,
  input  logic [NDIGITS-1:0]     digit_en,
  output logic [7*NDIGITS-1:0]   segments,
  output logic                   overflow
);

  localparam int W     = 4 * NDIGITS;
  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
  localparam logic [63:0]      DEC_MAX  = 64'(10 ** NDIGITS) - 64'd1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           digits_q, digits_d;     // committed display digits
  logic [W-1:0]           shift_q, shift_d;       // binary being shifted out
  logic [W-1:0]           bcd_q, bcd_d;           // BCD accumulator
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;           // committed overflow
  logic                   ovf_pend_q, ovf_pend_d; // overflow of the load in flight
  logic                   lz_q, lz_d;
  logic                   lz_pend_q, lz_pend_d;
  logic                   loaded_q, loaded_d;
  logic [7*NDIGITS-1:0]   segments_q, segments_d;
  logic                   overflow_q, overflow_d;

  logic [W-1:0]           bcd_adj;
  logic [W-1:0]           bcd_step;
  logic [NDIGITS-1:0]     lz_mask;
  logic                   zero_run;
  logic                   blink_off;
  logic                   accept;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0001100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  // ---------------------------------------------------------------- blink
`ifdef HEX_DISPLAY_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;   // 1 = display on

  // Free-running regardless of the blink input so the phase stays steady.
  always_comb begin
    blink_cnt_d   = blink_cnt_q + BW'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BLINK_TC) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blink_off = blink & ~blink_phase_q;
`else
  logic unused_blink;
  assign unused_blink = blink;
  assign blink_off    = 1'b0;
`endif

  // ---------------------------------------------------- double-dabble step
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NDIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // BCD digits above NDIGITS fall off the top; that only happens on
  // overflow, where the dash display hides the digits anyway.
  assign bcd_step = {bcd_adj[W-2:0], shift_q[W-1]};

  // -------------------------------------------------------- load control
  assign accept   = in_valid && (state_q == S_IDLE);
  assign in_ready = (state_q == S_IDLE);

  always_comb begin
    state_d    = state_q;
    digits_d   = digits_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    ovf_pend_d = ovf_pend_q;
    lz_d       = lz_q;
    lz_pend_d  = lz_pend_q;
    loaded_d   = loaded_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_decimal) begin
            shift_d    = in_value;
            bcd_d      = '0;
            cnt_d      = '0;
            ovf_pend_d = (64'(in_value) > DEC_MAX);
            lz_pend_d  = blank_lz;
            state_d    = S_CONV;
          end else begin
            digits_d = in_value;
            ovf_d    = 1'b0;
            lz_d     = blank_lz;
            loaded_d = 1'b1;
          end
        end
      end
      S_CONV: begin
        shift_d = shift_q << 1;
        bcd_d   = bcd_step;
        cnt_d   = cnt_q + CNT_W'(1);
        // The last step's result goes straight to the display so the
        // commit lands on the W-th edge after accept.
        if (cnt_q == CNT_LAST) begin
          digits_d = bcd_step;
          ovf_d    = ovf_pend_q;
          lz_d     = lz_pend_q;
          loaded_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- segment output
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (digits_q[4*i +: 4] == 4'd0);
      if (lz_q && zero_run && (i != 0))
        lz_mask[i] = 1'b1;
    end
  end

  always_comb begin
    segments_d = '1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (!loaded_q || !digit_en[i] || blink_off)
        segments_d[7*i +: 7] = SEG_BLANK;
      else if (ovf_q)
        segments_d[7*i +: 7] = SEG_DASH;
      else if (lz_mask[i])
        segments_d[7*i +: 7] = SEG_BLANK;
      else
        segments_d[7*i +: 7] = glyph(digits_q[4*i +: 4]);
    end
  end

  // Overflow output is staged with segments so both change on the same edge.
  assign overflow_d = ovf_q;

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      digits_q   <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      lz_q       <= 1'b0;
      lz_pend_q  <= 1'b0;
      loaded_q   <= 1'b0;
      segments_q <= '1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      ovf_pend_q <= ovf_pend_d;
      lz_q       <= lz_d;
      lz_pend_q  <= lz_pend_d;
      loaded_q   <= loaded_d;
      segments_q <= segments_d;
      overflow_q <= overflow_d;
    end
  end

  assign segments = segments_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_hex_display_bank.sv
module tb_hex_display_bank;

  localparam int ND = 4;
  localparam int W  = 4 * ND;
  localparam int SW = 7 * ND;

  localparam logic [6:0] G0 = 7'b0000001;
  localparam logic [6:0] G1 = 7'b1001111;
  localparam logic [6:0] G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100;
  localparam logic [6:0] G5 = 7'b0100100;
  localparam logic [6:0] G6 = 7'b0100000;
  localparam logic [6:0] G7 = 7'b0001111;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0001100;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GB = 7'b1100000;
  localparam logic [6:0] GC = 7'b0110001;
  localparam logic [6:0] GD = 7'b1000010;
  localparam logic [6:0] GE = 7'b0110000;
  localparam logic [6:0] GF = 7'b0111000;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b1111110;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_value;
  logic          in_decimal;
  logic          blank_lz;
  logic          blink;
  logic [ND-1:0] digit_en;
  logic [SW-1:0] segments;
  logic          overflow;

  typedef struct packed {
    logic [SW-1:0] seg;
    logic          ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  hex_display_bank #(.NDIGITS(ND), .BLINK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .in_decimal (in_decimal),
    .blank_lz   (blank_lz),
    .blink      (blink),
    .digit_en   (digit_en),
    .segments   (segments),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives a decimal load, keeps a stray hex request asserted during the
  // first conversion cycles, and counts cycles with in_ready low.
  task automatic run_decimal(input logic [W-1:0] value, input logic lz,
                             output int lows, output bit timeout);
    in_valid   = 1'b1;
    in_value   = value;
    in_decimal = 1'b1;
    blank_lz   = lz;
    step();
    in_decimal = 1'b0;
    in_value   = 16'hFFFF;
    lows       = 0;
    timeout    = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k == 4) in_valid = 1'b0;
      if (in_ready) begin
        timeout = 1'b0;
        break;
      end
      lows++;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_value = '0; in_decimal = 1'b0;
    blank_lz = 1'b0; blink = 1'b0; digit_en = '1;
    repeat (3) step();
    reset = 1'b0;
    n_vec++;
    if (segments !== {SW{1'b1}}) begin
      n_err++; $display("FAIL reset_segments: got %h expected %h", segments, {SW{1'b1}});
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow);
    end
    step();
    n_vec++;
    if (segments !== {SW{1'b1}}) begin
      n_err++; $display("FAIL reset_stays_blank: got %h expected all ones", segments);
    end
  endtask

  task automatic test_hex_load();
    exp_t e;
    in_valid = 1'b1; in_value = 16'h1234; in_decimal = 1'b0; blank_lz = 1'b0;
    exp_q.push_back('{seg: {G1, G2, G3, G4}, ovf: 1'b0});
    step();
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL hex_in_ready: got %b expected 1", in_ready);
    end
    step();
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL hex_1234: scoreboard empty, got %h", segments);
    end else begin
      e = exp_q.pop_front();
      if (segments !== e.seg || overflow !== e.ovf) begin
        n_err++;
        $display("FAIL hex_1234: got seg %b ovf %b expected seg %b ovf %b",
                 segments, overflow, e.seg, e.ovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    in_valid = 1'b1; in_value = 16'hABCD; in_decimal = 1'b0; blank_lz = 1'b0;
    exp_q.push_back('{seg: {GA, GB, GC, GD}, ovf: 1'b0});
    step();
    in_value = 16'hEF09;
    exp_q.push_back('{seg: {GE, GF, G0, G9}, ovf: 1'b0});
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL b2b_load%0d: scoreboard empty, got %h", k, segments);
      end else begin
        e = exp_q.pop_front();
        if (segments !== e.seg || overflow !== e.ovf) begin
          n_err++;
          $display("FAIL b2b_load%0d: got seg %b ovf %b expected seg %b ovf %b",
                   k, segments, overflow, e.seg, e.ovf);
        end
      end
      step();
    end
  endtask

  task automatic test_decimal();
    exp_t e;
    int   lows;
    bit   timeout;
    exp_q.push_back('{seg: {G1, G2, G3, G4}, ovf: 1'b0});
    run_decimal(16'd1234, 1'b0, lows, timeout);
    n_vec++;
    if (timeout || lows != W) begin
      n_err++; $display("FAIL dec_busy_cycles: got %0d (timeout %0d) expected %0d", lows, timeout, W);
    end
    step();
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL dec_1234: scoreboard empty, got %h", segments);
    end else begin
      e = exp_q.pop_front();
      if (segments !== e.seg || overflow !== e.ovf) begin
        n_err++;
        $display("FAIL dec_1234: got seg %b ovf %b expected seg %b ovf %b",
                 segments, overflow, e.seg, e.ovf);
      end
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    int   lows;
    bit   timeout;
    exp_q.push_back('{seg: {DS, DS, DS, DS}, ovf: 1'b1});
    run_decimal(16'd10000, 1'b0, lows, timeout);
    n_vec++;
    if (timeout || lows != W) begin
      n_err++; $display("FAIL ovf_busy_cycles: got %0d (timeout %0d) expected %0d", lows, timeout, W);
    end
    step();
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL dec_10000: scoreboard empty, got %h", segments);
    end else begin
      e = exp_q.pop_front();
      if (segments !== e.seg || overflow !== e.ovf) begin
        n_err++;
        $display("FAIL dec_10000: got seg %b ovf %b expected seg %b ovf %b",
                 segments, overflow, e.seg, e.ovf);
      end
    end
    in_valid = 1'b1; in_value = 16'h0000; in_decimal = 1'b0; blank_lz = 1'b0;
    exp_q.push_back('{seg: {G0, G0, G0, G0}, ovf: 1'b0});
    step();
    in_valid = 1'b0;
    step();
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL ovf_clear: scoreboard empty, got %h", segments);
    end else begin
      e = exp_q.pop_front();
      if (segments !== e.seg || overflow !== e.ovf) begin
        n_err++;
        $display("FAIL ovf_clear: got seg %b ovf %b expected seg %b ovf %b",
                 segments, overflow, e.seg, e.ovf);
      end
    end
  endtask

  task automatic test_lz_and_mask();
    exp_t e;
    in_valid = 1'b1; in_value = 16'h00A0; in_decimal = 1'b0; blank_lz = 1'b1;
    exp_q.push_back('{seg: {BL, BL, GA, G0}, ovf: 1'b0});
    step();
    in_value = 16'h0000;
    exp_q.push_back('{seg: {BL, BL, BL, G0}, ovf: 1'b0});
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL lz_load%0d: scoreboard empty, got %h", k, segments);
      end else begin
        e = exp_q.pop_front();
        if (segments !== e.seg || overflow !== e.ovf) begin
          n_err++;
          $display("FAIL lz_load%0d: got seg %b ovf %b expected seg %b ovf %b",
                   k, segments, overflow, e.seg, e.ovf);
        end
      end
      if (k == 0) step();
    end
    digit_en = 4'b1110;
    exp_q.push_back('{seg: {BL, BL, BL, BL}, ovf: 1'b0});
    step();
    digit_en = 4'b1111;
    exp_q.push_back('{seg: {BL, BL, BL, G0}, ovf: 1'b0});
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL mask_step%0d: scoreboard empty, got %h", k, segments);
      end else begin
        e = exp_q.pop_front();
        if (segments !== e.seg || overflow !== e.ovf) begin
          n_err++;
          $display("FAIL mask_step%0d: got seg %b ovf %b expected seg %b ovf %b",
                   k, segments, overflow, e.seg, e.ovf);
        end
      end
      if (k == 0) step();
    end
  endtask

  task automatic test_blink();
    logic [SW-1:0] vis;
    bit            blank_s[16];
    int            nblank;
    int            bad_alt;
    vis = {BL, BL, BL, G0};
    blink = 1'b1;
    nblank = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      blank_s[k] = (segments === {SW{1'b1}});
      if (blank_s[k]) nblank++;
      n_vec++;
`ifdef HEX_DISPLAY_BLINK_EN
      if (segments !== vis && segments !== {SW{1'b1}}) begin
        n_err++; $display("FAIL blink_sample%0d: got %b expected %b or all ones", k, segments, vis);
      end
`else
      if (segments !== vis) begin
        n_err++; $display("FAIL noblink_sample%0d: got %b expected %b", k, segments, vis);
      end
`endif
    end
`ifdef HEX_DISPLAY_BLINK_EN
    bad_alt = 0;
    for (int k = 4; k < 16; k++)
      if (blank_s[k] == blank_s[k-4]) bad_alt++;
    n_vec++;
    if (nblank != 8 || bad_alt != 0) begin
      n_err++; $display("FAIL blink_period: got %0d blank samples, %0d non-alternating, expected 8 and 0", nblank, bad_alt);
    end
`else
    bad_alt = 0;
    n_vec++;
    if (nblank != 0) begin
      n_err++; $display("FAIL noblink_blanks: got %0d blank samples expected 0", nblank);
    end
`endif
    blink = 1'b0;
    step();
    n_vec++;
    if (segments !== vis) begin
      n_err++; $display("FAIL blink_release: got %b expected %b", segments, vis);
    end
  endtask

  task automatic test_reset_mid_conv();
    exp_t e;
    in_valid = 1'b1; in_value = 16'd1234; in_decimal = 1'b1; blank_lz = 1'b0;
    step();
    in_valid = 1'b0; in_decimal = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL abort_in_ready: got %b expected 1", in_ready);
    end
    n_vec++;
    if (segments !== {SW{1'b1}}) begin
      n_err++; $display("FAIL abort_segments: got %h expected all ones", segments);
    end
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL abort_overflow: got %b expected 0", overflow);
    end
    repeat (20) step();
    n_vec++;
    if (segments !== {SW{1'b1}} || in_ready !== 1'b1) begin
      n_err++; $display("FAIL abort_no_commit: got seg %h ready %b expected all ones and 1", segments, in_ready);
    end
    in_valid = 1'b1; in_value = 16'h5678; in_decimal = 1'b0; blank_lz = 1'b0;
    exp_q.push_back('{seg: {G5, G6, G7, G8}, ovf: 1'b0});
    step();
    in_valid = 1'b0;
    step();
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++; $display("FAIL after_abort_hex: scoreboard empty, got %h", segments);
    end else begin
      e = exp_q.pop_front();
      if (segments !== e.seg || overflow !== e.ovf) begin
        n_err++;
        $display("FAIL after_abort_hex: got seg %b ovf %b expected seg %b ovf %b",
                 segments, overflow, e.seg, e.ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hex_load();
    test_back_to_back();
    test_decimal();
    test_overflow();
    test_lz_and_mask();
    test_blink();
    test_reset_mid_conv();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
